// File: rtl/bcd_display_pkg.sv
// bcd_display_pkg: FSM states, segment patterns and nibble-count helper for the BCD display driver
package bcd_display_pkg;
  typedef enum logic [1:0] {S_IDLE, S_CONV, S_LOAD} state_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b1111110;
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
    7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
    7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
    7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };
  function automatic int nibble_count(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: digit/blank/dash to active-low a..g pattern (i_digit, i_hex, i_blank, i_dash -> o_seg)
module seg7_decode
  import bcd_display_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_hex,
  input  logic       i_blank,
  input  logic       i_dash,
  output logic [6:0] o_seg
);
  always_comb o_seg = i_dash ? SEG_DASH :
                      (i_blank || (!i_hex && i_digit > 4'd9)) ? SEG_BLANK : SEG_TABLE[i_digit];
endmodule

// File: rtl/bcd_display_driver.sv
// bcd_display_driver: binary to decimal (shift-add-3) or hex seven-segment driver (i_clock, i_reset, i_start, i_valor, i_hex_mode -> o_busy, o_done, o_overflow, o_hex)
module bcd_display_driver
  import bcd_display_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int DIGITS        = 5,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [WIDTH-1:0]      i_valor,
  input  logic                  i_hex_mode,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow,
  output logic [7*DIGITS-1:0]   o_hex
);
  localparam int NB = nibble_count(WIDTH);
  localparam int HB = (WIDTH + 3) / 4;
  localparam int NM = NB > HB ? NB : HB;
  localparam int NT = NM > DIGITS ? NM : DIGITS;
  localparam int LW = 4 * NT;
  localparam int CW = $clog2(WIDTH + 1);
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_shift;
  logic [4*NB-1:0] r_bcd, w_adj;
  logic r_hex_mode, r_done, r_overflow;
  logic [CW-1:0] r_cnt;
  logic [7*DIGITS-1:0] r_hex, w_seg;
  logic [LW-1:0] w_val;
  logic [DIGITS-1:0] w_blank;
  logic w_ovf, w_last;
  always_comb begin
    w_adj = r_bcd;
    for (int n = 0; n < NB; n++)
      w_adj[4*n+:4] = r_bcd[4*n+:4] >= 4'd5 ? r_bcd[4*n+:4] + 4'd3 : r_bcd[4*n+:4];
  end
  assign w_last = r_cnt == CW'(1);
  always_comb begin
    w_next = S_IDLE;
    w_next = r_state == S_IDLE ? (i_start ? (i_hex_mode ? S_LOAD : S_CONV) : S_IDLE) :
             r_state == S_CONV ? (w_last ? S_LOAD : S_CONV) : S_IDLE;
  end
  // In hex mode the shift register still holds the captured value untouched.
  assign w_val = r_hex_mode ? LW'(r_shift) : LW'(r_bcd);
  assign w_ovf = |(w_val >> (4 * DIGITS));
  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    // A digit is leading if it and every digit above it are zero; digit 0 always shows.
    assign w_blank[k] = BLANK_LEADING != 0 && k != 0 && w_val[LW-1:4*k] == '0;
    seg7_decode u_dec (
      .i_digit(w_val[4*k+:4]),
      .i_hex  (r_hex_mode),
      .i_blank(w_blank[k]),
      .i_dash (w_ovf),
      .o_seg  (w_seg[7*k+:7])
    );
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_hex      <= '1;
    end else begin
      r_state <= w_next;
      r_done  <= r_state == S_LOAD;
      if (r_state == S_LOAD) begin
        r_hex      <= w_seg;
        r_overflow <= w_ovf;
      end
    end
  end
  always_ff @(posedge i_clock) begin
    if (r_state == S_IDLE && i_start) begin
      r_shift    <= i_valor;
      r_hex_mode <= i_hex_mode;
      r_bcd      <= '0;
      r_cnt      <= CW'(WIDTH);
    end else if (r_state == S_CONV) begin
      r_bcd   <= {w_adj[4*NB-2:0], r_shift[WIDTH-1]};
      r_shift <= r_shift << 1;
      r_cnt   <= r_cnt - CW'(1);
    end
  end
  assign o_busy     = r_state != S_IDLE;
  assign o_done     = r_done;
  assign o_overflow = r_overflow;
  assign o_hex      = r_hex;
endmodule

// File: tb/tb_bcd_display_driver.sv
// tb_bcd_display_driver: scoreboard bench over three driver configurations against an arithmetic display model
module tb_bcd_display_driver;
  logic clk = 0, rst = 1, start = 0, hex_mode = 0;
  logic [15:0] valor = 0;
  logic b5, d5, o5, b4, d4, o4, bn, dn, on_;
  logic [34:0] h5, hn;
  logic [27:0] h4;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  bcd_display_driver #(.WIDTH(16), .DIGITS(5), .BLANK_LEADING(1)) u_dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_valor(valor), .i_hex_mode(hex_mode),
    .o_busy(b5), .o_done(d5), .o_overflow(o5), .o_hex(h5));
  bcd_display_driver #(.WIDTH(16), .DIGITS(4), .BLANK_LEADING(1)) u_d4 (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_valor(valor), .i_hex_mode(hex_mode),
    .o_busy(b4), .o_done(d4), .o_overflow(o4), .o_hex(h4));
  bcd_display_driver #(.WIDTH(16), .DIGITS(5), .BLANK_LEADING(0)) u_nb (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_valor(valor), .i_hex_mode(hex_mode),
    .o_busy(bn), .o_done(dn), .o_overflow(on_), .o_hex(hn));
  typedef struct {
    logic [34:0] h5; logic o5; logic [27:0] h4; logic o4; logic [34:0] hn; logic onb; int cyc;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int total = 0, bad = 0;
  bit mon_en = 0, exp_busy;
  int busy_from = 0, busy_to = 0;
  logic [6:0] pat [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
                          7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                          7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [34:0] model(input int v, input bit hx, input int nd, input bit bl, output bit ovf);
    int base, t, top;
    int dg[8];
    logic [34:0] r;
    base = hx ? 16 : 10;
    t = v;
    top = 0;
    r = '1;
    ovf = 0;
    for (int i = 0; i < 8; i++) begin
      dg[i] = t % base;
      t = t / base;
    end
    for (int i = nd; i < 8; i++) if (dg[i] != 0) ovf = 1;
    for (int i = 0; i < nd; i++) if (dg[i] != 0) top = i;
    for (int i = 0; i < nd; i++)
      r[7*i+:7] = ovf ? 7'b1111110 : (bl && i > top) ? 7'b1111111 : pat[dg[i]];
    return r;
  endfunction
  always @(negedge clk) if (mon_en) begin
    exp_busy = cyc >= busy_from && cyc < busy_to;
    chk("busy", {b5, b4, bn}, {3{exp_busy}});
    if (d5 | d4 | dn) begin
      if (q.size() == 0) chk("spurious_done", {d5, d4, dn}, 3'b000);
      else begin
        e = q.pop_front();
        chk("latency", cyc, e.cyc);
        chk("done_all", {d5, d4, dn}, 3'b111);
        chk("hex_d5", h5, e.h5);
        chk("ovf_d5", o5, e.o5);
        chk("hex_d4", h4, e.h4);
        chk("ovf_d4", o4, e.o4);
        chk("hex_noblank", hn, e.hn);
        chk("ovf_noblank", on_, e.onb);
      end
    end
  end
  task automatic issue(input int v, input bit hx);
    exp_t ne;
    bit ov;
    logic [34:0] t;
    int lat;
    @(posedge clk); #1;
    start = 1; valor = v[15:0]; hex_mode = hx;
    if (cyc >= busy_to) begin
      lat = hx ? 2 : 18;
      ne.h5 = model(v, hx, 5, 1, ov); ne.o5 = ov;
      t = model(v, hx, 4, 1, ov); ne.h4 = t[27:0]; ne.o4 = ov;
      ne.hn = model(v, hx, 5, 0, ov); ne.onb = ov;
      ne.cyc = cyc + lat;
      q.push_back(ne);
      busy_from = cyc + 1;
      busy_to = cyc + lat;
    end
    @(posedge clk); #1;
    start = 0; valor = 16'($urandom); hex_mode = 1'($urandom);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 40 && cyc < busy_to; i++) @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset(input bit with_start);
    @(posedge clk); #1;
    rst = 1; start = with_start;
    if (busy_to > cyc) busy_to = cyc + 1;
    q.delete();
    repeat (3) @(posedge clk);
    #1; rst = 0; start = 0;
    @(negedge clk);
    chk("rst_hex_d5", h5, {35{1'b1}});
    chk("rst_hex_d4", h4, {28{1'b1}});
    chk("rst_flags", {b5, d5, o5, b4, d4, o4, bn, dn, on_}, 9'b0);
  endtask
  int dv[7] = '{1234, 0, 65535, 7, 16'hBEEF, 12345, 9999};
  bit dh[7] = '{0, 0, 0, 0, 1, 0, 0};
  int v;
  initial begin
    do_reset(1);
    mon_en = 1;
    for (int i = 0; i < 7; i++) begin
      issue(dv[i], dh[i]);
      wait_idle();
      if (i == 0) chk("lit_1234", h5, {7'b1111111, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100});
    end
    issue(500, 0);
    repeat (3) @(posedge clk);
    issue(7, 0);
    wait_idle();
    chk("lit_500", h5, {7'b1111111, 7'b1111111, 7'b0100100, 7'b0000001, 7'b0000001});
    issue(321, 0);
    repeat (8) @(posedge clk);
    do_reset(0);
    repeat (25) @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 20)) begin
        @(posedge clk); #1;
        valor = 16'($urandom);
      end
      case ($urandom_range(0, 3))
        0: v = $urandom_range(0, 99);
        1: v = $urandom_range(9990, 10010);
        default: v = $urandom_range(0, 65535);
      endcase
      issue(v, 1'($urandom_range(0, 1)));
    end
    wait_idle();
    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
